hevc_luma_hfir_stream: RTL

Streaming, parametrised HEVC luma horizontal interpolation engine. It accepts one integer pixel per cycle over a ready/valid handshake and applies the HEVC 8-tap luma filter selected per row (integer, A=1/4, B=1/2, C=3/4). It emits either rounded/clipped pixels or raw 16-bit intermediates for a following vertical stage. It replaces the fixed flattened-block interpolator with a row-streaming datapath that has configurable row width, block height, bit depth and output mode.

---
 rtl/hevc_luma_hfir_stream.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/hevc_luma_hfir_stream.sv
// hevc_luma_hfir_stream: HEVC 8-tap luma horizontal interpolation over a row-streamed pixel input.
// Latency: the output for a window completed by an accept appears two edges after that accept.
// Backpressure: the whole pipeline (counters, taps, stages) freezes while out_valid && !out_ready.
module hevc_luma_hfir_stream #(
   parameter int BIT_DEPTH = 8,
   parameter int ROW_WIDTH = 8,
   parameter int ROWS      = 8,
   parameter bit RAW_OUT   = 1'b0,
   localparam int OUT_W    = RAW_OUT ? 16 : BIT_DEPTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BIT_DEPTH-1:0] in_pixel,
   input  logic [1:0]           in_frac,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [OUT_W-1:0]     out_pixel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 out_last_blk
);

   localparam int ACC_W      = BIT_DEPTH + 8;
   localparam int IN_PER_ROW = ROW_WIDTH + 7;
   localparam int COL_W      = $clog2(IN_PER_ROW);
   localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int MAX_PIX    = (1 << BIT_DEPTH) - 1;

   localparam logic [COL_W-1:0] LAST_COL      = COL_W'(IN_PER_ROW - 1);
   localparam logic [COL_W-1:0] FIRST_WIN_COL = COL_W'(7);
   localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(ROWS - 1);

   // Tap weights t0..t7 for the selected fractional position (t0 is the oldest pixel).
   function automatic logic signed [7:0] tap_coef(input logic [1:0] frac, input int idx);
      logic signed [7:0] c [8];
      case (frac)
         2'd1:    c = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
         2'd2:    c = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
         2'd3:    c = '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};
         default: c = '{8'sd0, 8'sd0, 8'sd0, 8'sd64, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
      endcase
      return c[idx[2:0]];
   endfunction

   logic                 adv;
   logic [COL_W-1:0]     col_q, col_d;
   logic [ROW_W-1:0]     row_q, row_d;
   logic [1:0]           frac_q, frac_d;
   logic [BIT_DEPTH-1:0] sr_q [8];
   logic [BIT_DEPTH-1:0] sr_d [8];
   logic                 w_vld_q, w_vld_d, w_last_q, w_last_d, w_lblk_q, w_lblk_d;

   logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic                    s1_vld_q, s1_vld_d, s1_last_q, s1_last_d, s1_lblk_q, s1_lblk_d;

   logic signed [ACC_W:0]   rnd_v, sh_v;
   logic signed [ACC_W-1:0] raw_v;
   logic [BIT_DEPTH-1:0]    clip_v;
   logic [OUT_W-1:0]        out_pix_q, out_pix_d;
   logic                    out_vld_q, out_vld_d, out_last_q, out_last_d, out_lblk_q, out_lblk_d;

   // Input side: handshake, row/column counters, frac capture and the tap shift register
   always_comb begin
      adv      = !out_vld_q || out_ready;
      col_d    = col_q;
      row_d    = row_q;
      frac_d   = frac_q;
      sr_d     = sr_q;
      w_vld_d  = w_vld_q;
      w_last_d = w_last_q;
      w_lblk_d = w_lblk_q;
      if (adv) begin
         // An idle cycle with adv high injects a bubble into the pipe.
         w_vld_d  = 1'b0;
         w_last_d = 1'b0;
         w_lblk_d = 1'b0;
         if (in_valid) begin
            for (int i = 0; i < 7; i++) begin
               sr_d[i] = sr_q[i+1];
            end
            sr_d[7] = in_pixel;
            if (col_q == '0) begin
               frac_d = in_frac;
            end
            if (col_q >= FIRST_WIN_COL) begin
               w_vld_d  = 1'b1;
               w_last_d = (col_q == LAST_COL);
               w_lblk_d = (col_q == LAST_COL) && (row_q == LAST_ROW);
            end
            if (col_q == LAST_COL) begin
               col_d = '0;
               row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end
      end
   end

   // Datapath: MAC over the window into S1, then round/clip or raw scaling into the output stage
   always_comb begin
      acc_sum = '0;
      for (int i = 0; i < 8; i++) begin
         acc_sum = acc_sum + ACC_W'($signed({1'b0, sr_q[i]})) * ACC_W'(tap_coef(frac_q, i));
      end
      rnd_v  = (ACC_W+1)'(acc_q) + (ACC_W+1)'(32);
      sh_v   = rnd_v >>> 6;
      if (sh_v[ACC_W]) begin
         clip_v = '0;
      end else if (sh_v > (ACC_W+1)'(MAX_PIX)) begin
         clip_v = BIT_DEPTH'(MAX_PIX);
      end else begin
         clip_v = sh_v[BIT_DEPTH-1:0];
      end
      raw_v      = acc_q >>> (BIT_DEPTH - 8);
      acc_d      = acc_q;
      s1_vld_d   = s1_vld_q;
      s1_last_d  = s1_last_q;
      s1_lblk_d  = s1_lblk_q;
      out_pix_d  = out_pix_q;
      out_vld_d  = out_vld_q;
      out_last_d = out_last_q;
      out_lblk_d = out_lblk_q;
      if (adv) begin
         acc_d      = acc_sum;
         s1_vld_d   = w_vld_q;
         s1_last_d  = w_last_q;
         s1_lblk_d  = w_lblk_q;
         out_pix_d  = RAW_OUT ? OUT_W'(16'(raw_v)) : OUT_W'(clip_v);
         out_vld_d  = s1_vld_q;
         out_last_d = s1_last_q;
         out_lblk_d = s1_lblk_q;
      end
   end

   // State registers; reset discards any partial row and empties the pipe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q      <= '0;
         row_q      <= '0;
         frac_q     <= '0;
         for (int i = 0; i < 8; i++) begin
            sr_q[i] <= '0;
         end
         w_vld_q    <= 1'b0;
         w_last_q   <= 1'b0;
         w_lblk_q   <= 1'b0;
         acc_q      <= '0;
         s1_vld_q   <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_lblk_q  <= 1'b0;
         out_pix_q  <= '0;
         out_vld_q  <= 1'b0;
         out_last_q <= 1'b0;
         out_lblk_q <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         frac_q     <= frac_d;
         for (int i = 0; i < 8; i++) begin
            sr_q[i] <= sr_d[i];
         end
         w_vld_q    <= w_vld_d;
         w_last_q   <= w_last_d;
         w_lblk_q   <= w_lblk_d;
         acc_q      <= acc_d;
         s1_vld_q   <= s1_vld_d;
         s1_last_q  <= s1_last_d;
         s1_lblk_q  <= s1_lblk_d;
         out_pix_q  <= out_pix_d;
         out_vld_q  <= out_vld_d;
         out_last_q <= out_last_d;
         out_lblk_q <= out_lblk_d;
      end
   end

   assign in_ready     = adv;
   assign out_pixel    = out_pix_q;
   assign out_valid    = out_vld_q;
   assign out_last     = out_last_q;
   assign out_last_blk = out_lblk_q;

endmodule
